// File: rtl/spw_intr_pkg.sv
// Shared constants, FSM state types and byte-lane helper for the SpaceWire
// AXI4-Lite interrupt controller.
package spw_intr_pkg;

    localparam logic [4:0] ADDR_GIE = 5'h00;
    localparam logic [4:0] ADDR_IER = 5'h04;
    localparam logic [4:0] ADDR_ISR = 5'h08;
    localparam logic [4:0] ADDR_IAR = 5'h0C;
    localparam logic [4:0] ADDR_IPR = 5'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    // Expand a 4-bit write strobe into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) m[b*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/spw_intr_capture.sv
// Per-source interrupt status capture; SPW_INTR_EDGE_EN selects rising-edge
// capture, otherwise sources are level-captured every cycle they are high.
module spw_intr_capture #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_src,
    input  logic [W-1:0] i_clr,
    output logic [W-1:0] o_isr
);

    logic [W-1:0] r_isr;
    logic [W-1:0] w_set;

`ifdef SPW_INTR_EDGE_EN
    logic [W-1:0] r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_prev <= '0;
        else       r_prev <= i_src;
    end

    assign w_set = i_src & ~r_prev;
`else
    assign w_set = i_src;
`endif

    // Set is OR-ed in after the clear so a same-cycle set always wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_isr <= '0;
        else       r_isr <= (r_isr & ~i_clr) | w_set;
    end

    assign o_isr = r_isr;

endmodule

// File: rtl/spw_axil_intr_slave.sv
// AXI4-Lite interrupt controller (GIE/IER/ISR/IAR/IPR) with registered irq.
// Build option: define SPW_INTR_EDGE_EN for rising-edge source capture.
module spw_axil_intr_slave
    import spw_intr_pkg::*;
#(
    parameter int C_NUM_INTR         = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_IRQ_ACTIVE_STATE = 1
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_NUM_INTR-1:0]           intr_in,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);

    localparam logic IRQ_ON = (C_IRQ_ACTIVE_STATE != 0);

    wr_state_t              r_wr_state;
    rd_state_t              r_rd_state;
    logic                   r_gie;
    logic [C_NUM_INTR-1:0]  r_ier;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_rvalid;
    logic [1:0]             r_rresp;
    logic [31:0]            r_rdata;
    logic                   r_irq;

    logic                   w_wr_hs;
    logic                   w_rd_hs;
    logic [4:0]             w_wr_off;
    logic [4:0]             w_rd_off;
    logic [31:0]            w_wmask;
    logic [31:0]            w_ier_ext;
    logic [31:0]            w_isr_ext;
    logic [31:0]            w_ier_new32;
    logic [31:0]            w_clr32;
    logic [C_NUM_INTR-1:0]  w_clr;
    logic [C_NUM_INTR-1:0]  w_isr;
    logic [31:0]            w_rdata;
    logic [1:0]             w_rresp;
    logic                   w_irq_next;
    logic                   w_unused;

    assign w_wr_off = {S_AXI_AWADDR[4:2], 2'b00};
    assign w_rd_off = {S_AXI_ARADDR[4:2], 2'b00};

    // Ready is combinational so the handshake cycle is the update cycle.
    assign w_wr_hs = !ARESET && (r_wr_state == WR_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_rd_hs = !ARESET && (r_rd_state == RD_IDLE) && S_AXI_ARVALID && !r_rvalid;

    always_comb begin
        w_ier_ext = '0;
        w_isr_ext = '0;
        w_ier_ext[C_NUM_INTR-1:0] = r_ier;
        w_isr_ext[C_NUM_INTR-1:0] = w_isr;
    end

    assign w_wmask     = strb_mask(S_AXI_WSTRB);
    assign w_ier_new32 = (w_ier_ext & ~w_wmask) | (S_AXI_WDATA & w_wmask);
    assign w_clr32     = S_AXI_WDATA & w_wmask;
    assign w_clr       = (w_wr_hs && w_wr_off == ADDR_IAR) ? w_clr32[C_NUM_INTR-1:0] : '0;

    spw_intr_capture #(
        .W (C_NUM_INTR)
    ) u_capture (
        .i_clk (ACLK),
        .i_rst (ARESET),
        .i_src (intr_in),
        .i_clr (w_clr),
        .o_isr (w_isr)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_state <= WR_IDLE;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_gie      <= 1'b0;
            r_ier      <= '0;
        end else begin
            case (r_wr_state)
                WR_IDLE: if (w_wr_hs) begin
                    r_bvalid   <= 1'b1;
                    r_bresp    <= (w_wr_off <= ADDR_IPR) ? RESP_OKAY : RESP_SLVERR;
                    r_wr_state <= WR_RESP;
                    if (w_wr_off == ADDR_GIE && S_AXI_WSTRB[0]) r_gie <= S_AXI_WDATA[0];
                    if (w_wr_off == ADDR_IER) r_ier <= w_ier_new32[C_NUM_INTR-1:0];
                end
                WR_RESP: if (S_AXI_BREADY) begin
                    r_bvalid   <= 1'b0;
                    r_wr_state <= WR_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        w_rresp = RESP_OKAY;
        case (w_rd_off)
            ADDR_GIE: w_rdata[0] = r_gie;
            ADDR_IER: w_rdata    = w_ier_ext;
            ADDR_ISR: w_rdata    = w_isr_ext;
            ADDR_IAR: w_rdata    = '0;
            ADDR_IPR: w_rdata    = w_isr_ext & w_ier_ext;
            default:  w_rresp    = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rd_state <= RD_IDLE;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                RD_IDLE: if (w_rd_hs) begin
                    r_rvalid   <= 1'b1;
                    r_rdata    <= w_rdata;
                    r_rresp    <= w_rresp;
                    r_rd_state <= RD_DATA;
                end
                RD_DATA: if (S_AXI_RREADY) begin
                    r_rvalid   <= 1'b0;
                    r_rd_state <= RD_IDLE;
                end
            endcase
        end
    end

    assign w_irq_next = r_gie && |(w_isr & r_ier);

    always_ff @(posedge ACLK) begin
        if (ARESET) r_irq <= !IRQ_ON;
        else        r_irq <= w_irq_next ? IRQ_ON : !IRQ_ON;
    end

    assign S_AXI_AWREADY = w_wr_hs;
    assign S_AXI_WREADY  = w_wr_hs;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = w_rd_hs;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign irq           = r_irq;

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                        S_AXI_ARADDR[1:0], w_ier_new32, w_clr32};

endmodule

// File: doc/spw_axil_intr_slave.md
# spw_axil_intr_slave

AXI4-Lite slave interrupt controller for the SpaceWire light AXI IP: the responder on the S_AXI_INTR port that the system's AXI4-Lite master drives. It latches up to C_NUM_INTR interrupt sources from the SpaceWire core (rx-ready, tx-empty, link-error, time-code). It exposes global enable, per-source enable, status, acknowledge and pending registers, and drives a single registered `irq` line.

## Interface
- C_NUM_INTR, 1 — number of interrupt sources, 1..32.
- C_S_AXI_DATA_WIDTH, 32 — AXI data width, fixed at 32.
- C_S_AXI_ADDR_WIDTH, 5 — byte address width; 8 word slots.
- C_IRQ_ACTIVE_STATE, 1 — level of `irq` when asserted.

Ports:
- ACLK  in  1  — single clock; all logic on rising edge.
- ARESET  in  1  — synchronous, active-high reset.
- intr_in  in  C_NUM_INTR  — interrupt sources, synchronous to ACLK.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  5/3/1/1  — write address channel; AWPROT ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  — write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  — write response channel.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  5/3/1/1  — read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  — read data channel.
- irq  out  1  — interrupt request.

## Operation
Register map (byte offsets):
- 0x00 GIE: bit0 global enable, R/W.
- 0x04 IER: per-source enable, R/W.
- 0x08 ISR: latched status, RO.
- 0x0C IAR: write-1-to-clear into ISR; reads 0.
- 0x10 IPR: ISR & IER, RO.

Decoding and responses:
- Offsets 0x14–0x1C are unmapped: reads return 0, and reads and writes respond SLVERR (2'b10).
- All mapped accesses respond OKAY.
- WSTRB gates byte lanes on GIE and IER. IAR honours WSTRB per byte.
- Bits at or above C_NUM_INTR read 0 and ignore writes.

Write FSM, states IDLE → RESP:
- In IDLE, when AWVALID && WVALID are both high, AWREADY and WREADY pulse high together for one cycle, the register update is applied, and the FSM moves to RESP.
- In RESP, BVALID is held until BREADY, then the FSM returns to IDLE.
- Only one transaction is outstanding at a time. AW or W arriving alone waits with READY low.

Read FSM, states IDLE → DATA:
- In IDLE, when ARVALID is high and RVALID is low, ARREADY pulses for one cycle and RDATA/RRESP are registered.
- In DATA, RVALID, RDATA and RRESP are held stable until RREADY.

Interrupt logic:
- Status set: ISR[i] is set per source according to the capture mode (see Configuration).
- Simultaneous set and IAR clear on the same bit in the same cycle: set wins.
- irq_next = GIE[0] && |(ISR & IER); `irq` is registered from irq_next.

## Timing
- Reset values: all registers 0, AWREADY/WREADY/ARREADY/BVALID/RVALID 0, BRESP/RRESP/RDATA 0, `irq` = !C_IRQ_ACTIVE_STATE.
- Reset mid-transaction aborts it; no response is issued.
- Write: AW/W handshake in cycle N, BVALID in N+1, new register value visible to reads and irq logic from N+1.
- Read: ARREADY in cycle N, RVALID in N+1 with data reflecting register state at N.
- Source to status: edge on intr_in sampled in cycle N sets ISR in N+1. `irq` asserts in N+2.
- IAR write in N (handshake): ISR clears in N+1; `irq` deasserts in N+2 if no other pending bits remain.
- Reads and writes proceed concurrently. A read in the same cycle as a write returns the pre-write value.

## Configuration
- SPW_INTR_EDGE_EN defined: a rising edge on intr_in[i] sets ISR[i]. Each bit stays set until acknowledged, even if the source falls.
- Undefined (level mode): ISR[i] is set every cycle that intr_in[i] is high. An IAR clear takes effect only when the source is low.

## Structure
- Package spw_intr_pkg holds:
  - register offset constants ADDR_GIE/IER/ISR/IAR/IPR;
  - RESP_OKAY/RESP_SLVERR;
  - the write and read FSM state enums.
- One sub-module, spw_intr_capture: per-source prior-sample register, edge/level detect and ISR set/clear, instantiated once with width C_NUM_INTR.

## Test plan
- Reset, then read 0x00–0x10 → all return 0x0 OKAY, and `irq` is inactive.
- Write GIE=1 and IER=1, then pulse intr_in[0] for one cycle → `irq` active two cycles later; IPR reads 0x1.
- With `irq` active, write IAR=1 → `irq` deasserts within 2 cycles, and IPR reads 0x0. This also holds in edge mode with the source still high.
- Drive an IAR=1 write and a new intr_in[0] edge in the same cycle → ISR[0] remains 1 and `irq` stays active.
- Write IER with WSTRB=4'b0010 and data 0xFFFFFFFF at C_NUM_INTR=32 → IER reads 0x0000FF00.
- Read offset 0x18 → RRESP=SLVERR, RDATA=0. Stall BREADY for 5 cycles → BVALID held and no new AWREADY.
